// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory-port arbiter.
//   state_e - arbiter sequencer states
//   owner_e - which cache miss handler last held the memory port
//   BLK_WORDS / MEM_LAT - block size in words, memory read latency
//   IDX_W / OFF_W - word-index width and byte-offset width of a block
package mem_arb_pkg;

  localparam int unsigned BLK_WORDS = 8;
  localparam int unsigned MEM_LAT   = 4;
  localparam int unsigned IDX_W     = $clog2(BLK_WORDS);
  // Byte offset within a block: word index plus the byte-in-word bit.
  localparam int unsigned OFF_W     = IDX_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_IFILL,
    ST_DFILL,
    ST_DWRITE
  } state_e;

  typedef enum logic {
    OWN_I,
    OWN_D
  } owner_e;

endpackage

// File: rtl/blk_fill_ctr.sv
// blk_fill_ctr: issue and receive word counters for one block fill.
//   clk_i, rst_i   - clock, asynchronous active-high reset
//   start_i        - clears both counters and arms issuing (fill begins)
//   issue_en_i     - fill state active; advances issue count while issuing
//   recv_en_i      - a read word returned this cycle; advances receive count
//   issue_cnt_o    - index of the word being issued this cycle
//   recv_cnt_o     - index of the word being received this cycle
//   issuing_o      - reads still to be issued for the current block
//   issue_last_o   - issue count is at the final word
//   recv_last_o    - receive count is at the final word
module blk_fill_ctr #(
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             issue_en_i,
  input  logic             recv_en_i,
  output logic [CNT_W-1:0] issue_cnt_o,
  output logic [CNT_W-1:0] recv_cnt_o,
  output logic             issuing_o,
  output logic             issue_last_o,
  output logic             recv_last_o
);

  logic [CNT_W-1:0] issue_q, issue_d;
  logic [CNT_W-1:0] recv_q, recv_d;
  logic             issuing_q, issuing_d;

  assign issue_last_o = (issue_q == '1);
  assign recv_last_o  = (recv_q == '1);
  assign issue_cnt_o  = issue_q;
  assign recv_cnt_o   = recv_q;
  assign issuing_o    = issuing_q;

  always_comb begin
    issue_d   = issue_q;
    recv_d    = recv_q;
    issuing_d = issuing_q;
    if (start_i) begin
      issue_d   = '0;
      recv_d    = '0;
      issuing_d = 1'b1;
    end else begin
      // Counters wrap to zero after the last word, so they rest at 0.
      if (issue_en_i && issuing_q) begin
        issue_d = issue_q + 1'b1;
        if (issue_last_o) issuing_d = 1'b0;
      end
      if (recv_en_i) recv_d = recv_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      issue_q   <= '0;
      recv_q    <= '0;
      issuing_q <= 1'b0;
    end else begin
      issue_q   <= issue_d;
      recv_q    <= recv_d;
      issuing_q <= issuing_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the pipelined main-memory port between the I-cache
// and D-cache miss handlers. Grants one requester at a time and runs an
// 8-word block fill or a single-word write-through store.
//   clk, rst                         - clock, asynchronous active-high reset
//   i_req/i_addr                     - I-cache fill request (held until i_done)
//   i_grant/i_data_valid/i_done      - I-cache ownership, fill word, completion
//   d_req/d_we/d_addr/d_wdata        - D-cache fill (d_we=0) or store (d_we=1)
//   d_grant/d_data_valid/d_done      - D-cache ownership, fill word, completion
//   fill_data/fill_idx               - returned read word and its block index
//   mem_en/mem_wr/mem_addr/mem_wdata - memory request port
//   mem_rdata/mem_rvalid             - memory read return
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned BLK_WORDS = mem_arb_pkg::BLK_WORDS
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_req,
  input  logic [ADDR_W-1:0]              i_addr,
  output logic                           i_grant,
  output logic                           i_data_valid,
  output logic                           i_done,
  input  logic                           d_req,
  input  logic                           d_we,
  input  logic [ADDR_W-1:0]              d_addr,
  input  logic [DATA_W-1:0]              d_wdata,
  output logic                           d_grant,
  output logic                           d_data_valid,
  output logic                           d_done,
  output logic [DATA_W-1:0]              fill_data,
  output logic [$clog2(BLK_WORDS)-1:0]   fill_idx,
  output logic                           mem_en,
  output logic                           mem_wr,
  output logic [ADDR_W-1:0]              mem_addr,
  output logic [DATA_W-1:0]              mem_wdata,
  input  logic [DATA_W-1:0]              mem_rdata,
  input  logic                           mem_rvalid
);

  localparam int unsigned IW = $clog2(BLK_WORDS);
  localparam int unsigned OW = IW + 1;

  state_e              state_q, state_d;
  owner_e              last_q, last_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;

  logic                take_d;
  logic                start;
  logic                in_fill;
  logic                recv_en;
  logic [IW-1:0]       issue_cnt, recv_cnt;
  logic                issuing, issue_last, recv_last;
  logic [ADDR_W-1:0]   fill_addr;

  // D wins when it is the only requester, or on a tie when I was served last.
  assign take_d  = d_req && (!i_req || (last_q == OWN_I));
  assign in_fill = (state_q == ST_IFILL) || (state_q == ST_DFILL);
  assign recv_en = in_fill && mem_rvalid;
  assign start   = (state_q == ST_IDLE) &&
                   ((state_d == ST_IFILL) || (state_d == ST_DFILL));

  assign fill_addr = {addr_q[ADDR_W-1:OW], issue_cnt, 1'b0};

  blk_fill_ctr #(.CNT_W(IW)) u_ctr (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .issue_en_i  (in_fill),
    .recv_en_i   (recv_en),
    .issue_cnt_o (issue_cnt),
    .recv_cnt_o  (recv_cnt),
    .issuing_o   (issuing),
    .issue_last_o(issue_last),
    .recv_last_o (recv_last)
  );

  // State and request-capture registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      last_q  <= OWN_I;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Next-state: requests are only sampled in IDLE; address/data latched there.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (take_d) begin
          state_d = d_we ? ST_DWRITE : ST_DFILL;
          last_d  = OWN_D;
          addr_d  = d_addr;
          wdata_d = d_wdata;
        end else if (i_req) begin
          state_d = ST_IFILL;
          last_d  = OWN_I;
          addr_d  = i_addr;
        end
      end
      ST_IFILL, ST_DFILL: begin
        if (mem_rvalid && recv_last) state_d = ST_IDLE;
      end
      ST_DWRITE: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs decode registered state; only the read-return signals pass through.
  always_comb begin
    i_grant      = 1'b0;
    i_data_valid = 1'b0;
    i_done       = 1'b0;
    d_grant      = 1'b0;
    d_data_valid = 1'b0;
    d_done       = 1'b0;
    mem_en       = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    fill_data    = mem_rdata;
    fill_idx     = recv_cnt;
    unique case (state_q)
      ST_IFILL: begin
        i_grant      = 1'b1;
        i_data_valid = mem_rvalid;
        i_done       = mem_rvalid && recv_last;
        mem_en       = issuing;
        mem_addr     = issuing ? fill_addr : '0;
      end
      ST_DFILL: begin
        d_grant      = 1'b1;
        d_data_valid = mem_rvalid;
        d_done       = mem_rvalid && recv_last;
        mem_en       = issuing;
        mem_addr     = issuing ? fill_addr : '0;
      end
      ST_DWRITE: begin
        d_grant   = 1'b1;
        d_done    = 1'b1;
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = addr_q & ~ADDR_W'(1);
        mem_wdata = wdata_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with a 4-cycle-latency
// memory model returning (word address ^ 16'h5A5A) as read data.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req = 1'b0;
  logic [15:0] i_addr = '0;
  logic        i_grant, i_data_valid, i_done;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [15:0] d_addr = '0;
  logic [15:0] d_wdata = '0;
  logic        d_grant, d_data_valid, d_done;
  logic [15:0] fill_data;
  logic [2:0]  fill_idx;
  logic        mem_en, mem_wr;
  logic [15:0] mem_addr, mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        mem_rvalid = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_W   (16),
    .DATA_W   (16),
    .BLK_WORDS(8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_req       (i_req),
    .i_addr      (i_addr),
    .i_grant     (i_grant),
    .i_data_valid(i_data_valid),
    .i_done      (i_done),
    .d_req       (d_req),
    .d_we        (d_we),
    .d_addr      (d_addr),
    .d_wdata     (d_wdata),
    .d_grant     (d_grant),
    .d_data_valid(d_data_valid),
    .d_done      (d_done),
    .fill_data   (fill_data),
    .fill_idx    (fill_idx),
    .mem_en      (mem_en),
    .mem_wr      (mem_wr),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_rvalid  (mem_rvalid)
  );

  // Memory model: a read issued in cycle c returns in cycle c+4.
  logic [3:0]  pv = '0;
  logic [15:0] pa [4] = '{default: '0};

  always @(negedge clk) begin
    for (int i = 3; i > 0; i--) begin
      pv[i] = pv[i-1];
      pa[i] = pa[i-1];
    end
    pv[0] = mem_en & ~mem_wr;
    pa[0] = mem_addr;
  end

  always @(posedge clk) begin
    #1;
    mem_rvalid = pv[3];
    mem_rdata  = pv[3] ? (pa[3] ^ 16'h5A5A) : 16'h0000;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Runs one block fill starting at the current negedge. Checks every state
  // cycle 0..11 and the IDLE cycle 12. drop_at drops the owner's request in
  // that cycle; end_drop[0]/[1] drop i_req/d_req in cycle 11.
  task automatic do_fill(input bit own_d, input logic [15:0] addr,
                         input int drop_at, input bit [1:0] end_drop);
    logic [15:0] wa;
    if (own_d) begin
      d_req = 1'b1; d_we = 1'b0; d_addr = addr;
    end else begin
      i_req = 1'b1; i_addr = addr;
    end
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      if (k == 0) begin
        if (own_d) d_addr = ~addr; else i_addr = ~addr;
      end
      if (k == 12) begin
        chk("idle_i_grant", i_grant, 0);
        chk("idle_d_grant", d_grant, 0);
        chk("idle_mem_en", mem_en, 0);
        chk("idle_done", {i_done, d_done}, 0);
      end else begin
        chk("own_grant", own_d ? d_grant : i_grant, 1);
        chk("other_grant", own_d ? i_grant : d_grant, 0);
        chk("fill_mem_en", mem_en, (k < 8));
        chk("fill_mem_wr", mem_wr, 0);
        if (k < 8) begin
          wa = {addr[15:4], 3'(k), 1'b0};
          chk("fill_mem_addr", mem_addr, wa);
        end
        chk("own_dv", own_d ? d_data_valid : i_data_valid, (k >= 4));
        chk("other_dv", own_d ? i_data_valid : d_data_valid, 0);
        if (k >= 4) begin
          chk("fill_idx", fill_idx, k - 4);
          wa = {addr[15:4], 3'(k - 4), 1'b0} ^ 16'h5A5A;
          chk("fill_data", fill_data, wa);
        end
        chk("own_done", own_d ? d_done : i_done, (k == 11));
        chk("other_done", own_d ? i_done : d_done, 0);
      end
      if (k == drop_at) begin
        if (own_d) d_req = 1'b0; else i_req = 1'b0;
      end
      if (k == 11) begin
        if (end_drop[0]) i_req = 1'b0;
        if (end_drop[1]) d_req = 1'b0;
      end
    end
  endtask

  typedef struct {
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_addr;
  } wr_vec_t;

  wr_vec_t wv [4];

  initial begin
    wv[0] = '{16'h0041, 16'hBEEF, 16'h0040};
    wv[1] = '{16'h1234, 16'h0001, 16'h1234};
    wv[2] = '{16'hFFFF, 16'h8000, 16'hFFFE};
    wv[3] = '{16'h0000, 16'hFFFF, 16'h0000};

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_ctrl", {i_grant, i_data_valid, i_done, d_grant, d_data_valid,
                     d_done, mem_en, mem_wr}, 0);
    chk("rst_fill_idx", fill_idx, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    rst = 1'b0;

    // I-cache fill of block 0x1230
    do_fill(1'b0, 16'h1234, -1, 2'b01);

    // Single-word writes, inputs scrambled after latching
    for (int n = 0; n < 4; n++) begin
      d_req = 1'b1; d_we = 1'b1; d_addr = wv[n].addr; d_wdata = wv[n].wdata;
      @(negedge clk);
      d_addr = 16'h7777; d_wdata = 16'h3333; d_req = 1'b0;
      #1;
      chk("wr_d_grant", d_grant, 1);
      chk("wr_i_grant", i_grant, 0);
      chk("wr_mem_en_wr", {mem_en, mem_wr}, 2'b11);
      chk("wr_mem_addr", mem_addr, wv[n].exp_addr);
      chk("wr_mem_wdata", mem_wdata, wv[n].wdata);
      chk("wr_d_done", d_done, 1);
      chk("wr_d_dv", d_data_valid, 0);
      @(negedge clk);
      chk("wr_idle_grant", d_grant, 0);
      chk("wr_idle_mem", {mem_en, mem_wr, d_done}, 0);
    end

    // Request dropped in fill cycle 3: fill still completes
    do_fill(1'b0, 16'h2468, 3, 2'b01);

    // Tie after reset goes to D, then I two cycles after d_done, then D again
    do_reset();
    i_req = 1'b1; i_addr = 16'h4000;
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0100; d_wdata = 16'h1111;
    @(negedge clk);
    chk("tie1_d_grant", d_grant, 1);
    chk("tie1_i_grant", i_grant, 0);
    chk("tie1_write", {mem_wr, d_done}, 2'b11);
    d_req = 1'b0;
    @(negedge clk);
    chk("tie1_idle_i_grant", i_grant, 0);
    do_fill(1'b0, 16'h4000, -1, 2'b00);
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0202; d_wdata = 16'h2222;
    @(negedge clk);
    chk("tie2_d_grant", d_grant, 1);
    chk("tie2_i_grant", i_grant, 0);
    chk("tie2_mem_addr", mem_addr, 16'h0202);
    i_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    chk("tie2_idle", {i_grant, d_grant, mem_en}, 0);

    // Reset asserted in fill cycle 5
    i_req = 1'b1; i_addr = 16'h3000;
    for (int k = 0; k < 5; k++) @(negedge clk);
    @(negedge clk);
    chk("pre_rst_grant", i_grant, 1);
    chk("pre_rst_rvalid_dv", i_data_valid, 1);
    rst = 1'b1;
    #1;
    chk("midrst_grant", {i_grant, d_grant}, 0);
    chk("midrst_mem_en", mem_en, 0);
    chk("midrst_dv", i_data_valid, 0);
    chk("midrst_done", i_done, 0);
    chk("midrst_fill_idx", fill_idx, 0);
    i_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("stale_dv", {i_data_valid, d_data_valid}, 0);
      chk("stale_grant", {i_grant, d_grant}, 0);
    end
    do_fill(1'b1, 16'h0ABC, -1, 2'b10);

    // Back-to-back D fills with i_req held: D, I, D
    do_reset();
    i_req = 1'b1; i_addr = 16'h8880;
    do_fill(1'b1, 16'h1100, -1, 2'b00);
    do_fill(1'b0, 16'h8880, -1, 2'b00);
    do_fill(1'b1, 16'h2200, -1, 2'b11);
    @(negedge clk);
    chk("end_idle", {i_grant, d_grant, mem_en, i_data_valid, d_data_valid}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
